sdram_cmd_arbiter: RTL
======================

SDRAM_CMD_ARBITER -- requirements
Module: sdram_cmd_arbiter

Interface
REQ-001 Parameter PADD_SIZE, 24, width of requester and controller address.
REQ-002 Parameter REF_PERIOD, 1560, clk0 cycles between refresh requests (minimum 4).
REQ-003 Port clk0  in  1  sole clock; all state changes on rising edge.
REQ-004 Port reset  in  1  asynchronous, active-low reset.
REQ-005 Ports req0/req1  in  1  requester 0/1 access request; held high until matching gnt.
REQ-006 Ports wr0/wr1  in  1  1 = write, 0 = read; stable while req high.
REQ-007 Ports addr0/addr1  in  PADD_SIZE  requester address; stable while req high.
REQ-008 Ports gnt0/gnt1  out  1  one-cycle pulse: request accepted by controller.
REQ-009 Port cmack  in  1  controller command acknowledge.
REQ-010 Port ref_ack  in  1  controller refresh acknowledge.
REQ-011 Ports nop, reada, writea, refresh, preacharge, load_mod  out  1  registered controller command strobes.
REQ-012 Port caddr  out  PADD_SIZE  registered address for current command.
REQ-013 Port ref_req  out  1  refresh pending to controller.
REQ-014 Port ref_miss  out  1  sticky: refresh interval expired with refresh still pending.
REQ-015 Port busy  out  1  high in every state except IDLE.

Function
REQ-016 States: INIT_PRE, INIT_LMR, IDLE, CMD, REF; exactly one of reada/writea/refresh/preacharge/load_mod high in a non-IDLE state, nop = NOR of the five.
REQ-017 After reset release: INIT_PRE asserts preacharge, caddr = 0; on cmack sampled high -> INIT_LMR.
REQ-018 INIT_LMR asserts load_mod, caddr = 0; on cmack sampled high -> IDLE.
REQ-019 IDLE priority: ref_req first (-> REF, refresh high), else requester arbitration (-> CMD); at most one transition per cycle.
REQ-020 Arbitration: single requester wins; both requesting -> port not granted last wins; last-grant pointer resets to 1 so port 0 wins first conflict.
REQ-021 On IDLE->CMD: caddr latches winner address, reada = ~wr, writea = wr, both registered (visible next cycle).
REQ-022 CMD: strobe held until cmack sampled high; that edge drops strobe, pulses winner gnt for exactly one cycle, updates pointer, -> IDLE.
REQ-023 Minimum request-to-gnt latency from IDLE with no refresh pending: 2 cycles plus controller cmack delay.
REQ-024 REF: refresh held until ref_ack sampled high; that edge drops refresh, clears ref_req, -> IDLE; cmack ignored in REF.
REQ-025 Refresh timer: counter loads REF_PERIOD-1, decrements every cycle in all states including INIT, at 0 reloads and sets ref_req.
REQ-026 Timer expiry while ref_req already high sets ref_miss; ref_req stays single (no queued second refresh).
REQ-027 Timer expiry on same edge as ref_ack clearance: ref_req ends high (set wins).
REQ-028 Requests arriving in INIT or REF are held off, not dropped; gnt never issued without a completed CMD handshake.
REQ-029 Requester deasserting req before gnt in IDLE is not granted; after IDLE->CMD the command completes regardless.

Reset
REQ-030 Reset low: state INIT_PRE, all strobes 0, nop 1, gnt0/gnt1 0, caddr 0, ref_req 0, ref_miss 0, busy 1, timer REF_PERIOD-1, pointer 1.
REQ-031 Reset asserted mid-command abandons it immediately without gnt; init sequence restarts on release.

Configuration
REQ-032 Macro ARB_FIXED_PRIO_EN defined: requester 0 always wins conflicts, pointer unused; undefined: round-robin per REQ-020.

Verification (REF_PERIOD = 16, cmack/ref_ack returned 2 cycles after strobe)
REQ-033 Reset release -> preacharge then load_mod each acked, busy 0 afterward, no gnt during init.
REQ-034 req0=1, wr0=1, addr0=0x000123 in IDLE -> writea high, caddr 0x000123, one gnt0 pulse, writea low same edge.
REQ-035 req0 and req1 held high, reads, addr 0x10/0x20 -> grant order 0,1,0,1 (fixed-prio build: 0,0,0).
REQ-036 Timer expiry while CMD active -> ref_req high, refresh issued immediately after gnt, ref_req cleared on ref_ack.
REQ-037 ref_ack withheld 20 cycles -> ref_miss 1 after second expiry, sticky until reset.
REQ-038 Reset pulse during CMD -> strobes 0 asynchronously, no gnt, INIT_PRE restarts.

Source files
------------

// File: rtl/sdram_cmd_arbiter.sv
// sdram_cmd_arbiter
//   Two-port arbiter in front of an SDRAM controller. After reset it runs the
//   init sequence (precharge, then load mode). It then serves requester
//   commands and periodic refreshes, one at a time. Refresh always takes
//   priority over requesters while idle.
//
// Ports
//   clk0                 sole clock, rising edge
//   reset                asynchronous, active-low reset
//   req0/req1            access request, held until the matching gnt
//   wr0/wr1              1 = write, 0 = read
//   addr0/addr1          requester address
//   gnt0/gnt1            one-cycle pulse when the controller accepts the command
//   cmack                controller command acknowledge
//   ref_ack              controller refresh acknowledge
//   nop, reada, writea, refresh, preacharge, load_mod
//                        registered command strobes (nop = none active)
//   caddr                registered address of the current command
//   ref_req              refresh pending
//   ref_miss             sticky: refresh interval expired with refresh pending
//   busy                 high in every state except IDLE
//
// Build option
//   ARB_FIXED_PRIO_EN    defined: requester 0 always wins a conflict.
//                        undefined: round-robin arbitration; port 0 wins the
//                        first conflict after reset.
module sdram_cmd_arbiter #(
  parameter int PADD_SIZE  = 24,
  parameter int REF_PERIOD = 1560
) (
  input  logic                 clk0,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 wr0,
  input  logic                 wr1,
  input  logic [PADD_SIZE-1:0] addr0,
  input  logic [PADD_SIZE-1:0] addr1,
  output logic                 gnt0,
  output logic                 gnt1,
  input  logic                 cmack,
  input  logic                 ref_ack,
  output logic                 nop,
  output logic                 reada,
  output logic                 writea,
  output logic                 refresh,
  output logic                 preacharge,
  output logic                 load_mod,
  output logic [PADD_SIZE-1:0] caddr,
  output logic                 ref_req,
  output logic                 ref_miss,
  output logic                 busy
);

  localparam int TW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(REF_PERIOD - 1);
  localparam logic [TW-1:0] ONE    = TW'(1);

  typedef enum logic [2:0] {
    ST_INIT_PRE = 3'd0,
    ST_INIT_LMR = 3'd1,
    ST_IDLE     = 3'd2,
    ST_CMD      = 3'd3,
    ST_REF      = 3'd4
  } state_t;

  state_t                 state_r, state_nxt;
  logic                   win_r, win_nxt;
  logic                   cmd_wr_r, wr_nxt;
  logic [PADD_SIZE-1:0]   caddr_r, caddr_nxt;
  logic                   gnt0_r, gnt1_r, gnt0_nxt, gnt1_nxt;
  logic                   rd_r, wa_r, rf_r, pre_r, lmr_r, nop_r, busy_r;
  logic                   rd_nxt, wa_nxt, rf_nxt, pre_nxt, lmr_nxt, nop_nxt, busy_nxt;
  logic [TW-1:0]          cnt_r;
  logic                   ref_req_r, ref_miss_r;
  logic                   sel_s;
  logic                   expire_s, ref_clear_s;

  assign gnt0       = gnt0_r;
  assign gnt1       = gnt1_r;
  assign reada      = rd_r;
  assign writea     = wa_r;
  assign refresh    = rf_r;
  assign preacharge = pre_r;
  assign load_mod   = lmr_r;
  assign nop        = nop_r;
  assign busy       = busy_r;
  assign caddr      = caddr_r;
  assign ref_req    = ref_req_r;
  assign ref_miss   = ref_miss_r;

  assign expire_s    = (cnt_r == '0);
  assign ref_clear_s = (state_r == ST_REF) && ref_ack;

`ifdef ARB_FIXED_PRIO_EN
  // Winner select: port 0 whenever it is requesting.
  always_comb begin
    if (req0) sel_s = 1'b0;
    else      sel_s = 1'b1;
  end
`else
  logic last_r;

  // Winner select: on a conflict the port not granted last time wins.
  always_comb begin
    if (req0 && req1) sel_s = ~last_r;
    else if (req0)    sel_s = 1'b0;
    else              sel_s = 1'b1;
  end

  // Last-grant pointer, updated only when a command completes.
  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset)                            last_r <= 1'b1;
    else if (state_r == ST_CMD && cmack)   last_r <= win_r;
    else                                   last_r <= last_r;
  end
`endif

  // Next-state, latched command fields and next strobe values.
  always_comb begin
    state_nxt = state_r;
    win_nxt   = win_r;
    wr_nxt    = cmd_wr_r;
    caddr_nxt = caddr_r;
    gnt0_nxt  = 1'b0;
    gnt1_nxt  = 1'b0;
    case (state_r)
      ST_INIT_PRE: begin
        caddr_nxt = '0;
        // Only an ack of our own precharge strobe advances the sequence.
        if (cmack && pre_r) state_nxt = ST_INIT_LMR;
        else                state_nxt = ST_INIT_PRE;
      end
      ST_INIT_LMR: begin
        caddr_nxt = '0;
        if (cmack && lmr_r) state_nxt = ST_IDLE;
        else                state_nxt = ST_INIT_LMR;
      end
      ST_IDLE: begin
        if (ref_req_r) begin
          state_nxt = ST_REF;
        end else if (req0 || req1) begin
          state_nxt = ST_CMD;
          win_nxt   = sel_s;
          caddr_nxt = sel_s ? addr1 : addr0;
          wr_nxt    = sel_s ? wr1 : wr0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (cmack) begin
          state_nxt = ST_IDLE;
          gnt0_nxt  = ~win_r;
          gnt1_nxt  = win_r;
        end else begin
          state_nxt = ST_CMD;
        end
      end
      ST_REF: begin
        if (ref_ack) state_nxt = ST_IDLE;
        else         state_nxt = ST_REF;
      end
      default: begin
        state_nxt = ST_INIT_PRE;
        caddr_nxt = '0;
      end
    endcase

    // Strobes mirror the state being entered, so they appear with it.
    pre_nxt  = (state_nxt == ST_INIT_PRE);
    lmr_nxt  = (state_nxt == ST_INIT_LMR);
    rf_nxt   = (state_nxt == ST_REF);
    rd_nxt   = (state_nxt == ST_CMD) && !wr_nxt;
    wa_nxt   = (state_nxt == ST_CMD) && wr_nxt;
    nop_nxt  = ~(pre_nxt | lmr_nxt | rf_nxt | rd_nxt | wa_nxt);
    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State, command fields and all registered outputs except refresh status.
  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_INIT_PRE;
      win_r    <= 1'b0;
      cmd_wr_r <= 1'b0;
      caddr_r  <= '0;
      gnt0_r   <= 1'b0;
      gnt1_r   <= 1'b0;
      rd_r     <= 1'b0;
      wa_r     <= 1'b0;
      rf_r     <= 1'b0;
      pre_r    <= 1'b0;
      lmr_r    <= 1'b0;
      nop_r    <= 1'b1;
      busy_r   <= 1'b1;
    end else begin
      state_r  <= state_nxt;
      win_r    <= win_nxt;
      cmd_wr_r <= wr_nxt;
      caddr_r  <= caddr_nxt;
      gnt0_r   <= gnt0_nxt;
      gnt1_r   <= gnt1_nxt;
      rd_r     <= rd_nxt;
      wa_r     <= wa_nxt;
      rf_r     <= rf_nxt;
      pre_r    <= pre_nxt;
      lmr_r    <= lmr_nxt;
      nop_r    <= nop_nxt;
      busy_r   <= busy_nxt;
    end
  end

  // Free-running refresh interval timer, active in every state.
  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset)        cnt_r <= RELOAD;
    else if (expire_s) cnt_r <= RELOAD;
    else               cnt_r <= cnt_r - ONE;
  end

  // Refresh request and miss flags; a new expiry beats a same-edge clear.
  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      ref_req_r  <= 1'b0;
      ref_miss_r <= 1'b0;
    end else begin
      if (expire_s)         ref_req_r <= 1'b1;
      else if (ref_clear_s) ref_req_r <= 1'b0;
      else                  ref_req_r <= ref_req_r;
      // A pending refresh served on this very edge is not a miss.
      if (expire_s && ref_req_r && !ref_clear_s) ref_miss_r <= 1'b1;
      else                                        ref_miss_r <= ref_miss_r;
    end
  end

endmodule
